shape_processor_mc: RTL

//  Multi-channel successor of the single-CTRL shape processor register block. Holds one CTRL SFR
//  (SHAPE, OPERATION) per channel behind a bus write/read port. Applies KEEP/reserved/legality

---
 rtl/shape_processor_mc_pkg.sv | 67 ++++++
 rtl/shape_processor_mc_rr_arbiter.sv | 34 +++
 rtl/shape_processor_mc.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/shape_processor_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shape_processor_modeling (package)
//  Description : Shared encodings, CTRL register layout and legality helpers
//                for the multi-channel shape processor register block.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
package shape_processor_modeling;

    typedef enum logic [2:0] {
        CIRCLE     = 3'd0,
        RECTANGLE  = 3'd1,
        TRIANGLE   = 3'd2,
        KEEP_SHAPE = 3'd7
    } shape_e;

    typedef enum logic [6:0] {
        PERIMETER      = 7'd0,
        AREA           = 7'd1,
        IS_SQUARE      = 7'd2,
        IS_EQUILATERAL = 7'd3,
        IS_ISOSCELES   = 7'd4,
        KEEP_OPERATION = 7'd127
    } operation_e;

    // CTRL register layout: START[31], SHAPE[18:16], OPERATION[6:0]
    typedef struct packed {
        logic        start;
        logic [11:0] rsvd_hi;
        logic [2:0]  shape;
        logic [8:0]  rsvd_lo;
        logic [6:0]  operation;
    } ctrl_sfr_reg;

    // Register offsets within a channel (low address bit)
    localparam logic c_reg_ctrl   = 1'b0;
    localparam logic c_reg_status = 1'b1;

    // Bit positions of the write-side fields
    localparam int c_start_bit   = 31;
    localparam int c_shape_lsb   = 16;
    localparam int c_op_lsb      = 0;
    localparam int c_err_clr_bit = 1;

    function automatic logic is_reserved_shape(input logic [2:0] shape);
        return (shape >= 3'd3) && (shape <= 3'd6);
    endfunction

    function automatic logic is_reserved_operation(input logic [6:0] operation);
        return (operation >= 7'd5) && (operation <= 7'd126);
    endfunction

    // Both arguments must already have KEEP_* resolved to the stored value
    function automatic logic is_legal_combination(input logic [2:0] shape,
                                                  input logic [6:0] operation);
        logic v_ok;
        case (operation)
            PERIMETER, AREA:              v_ok = 1'b1;
            IS_SQUARE:                    v_ok = (shape == RECTANGLE);
            IS_EQUILATERAL, IS_ISOSCELES: v_ok = (shape == TRIANGLE);
            default:                      v_ok = 1'b0;
        endcase
        return v_ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shape_processor_mc_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shape_proc_rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first asserted
//                request at or after the pointer, wrapping to channel 0.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module shape_proc_rr_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int PTR_W        = 2
) (
    input  logic [NUM_CHANNELS-1:0] req,
    input  logic [PTR_W-1:0]        ptr,
    output logic [NUM_CHANNELS-1:0] grant,
    output logic                    grant_valid
);

    // Scan the request vector starting at the pointer; first hit wins
    always_comb begin
        int v_idx;
        grant       = '0;
        grant_valid = 1'b0;
        v_idx       = 0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            v_idx = (int'(ptr) + k) % NUM_CHANNELS;
            if (!grant_valid && req[v_idx]) begin
                grant[v_idx] = 1'b1;
                grant_valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/shape_processor_mc.sv
`default_nettype none
// ============================================================================
//  Module      : shape_processor_mc
//  Description : Multi-channel shape processor register block. One CTRL SFR
//                per channel with KEEP/reserved/legality checks, a registered
//                read port, and a round-robin arbitrated one-entry command
//                stage towards the compute engine.
//                Optional feature macro: SHAPE_PROC_ERR_IRQ_EN (sticky per
//                channel ERR with ERR_CLR and an error interrupt).
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module shape_processor_mc
    import shape_processor_modeling::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_W       = $clog2(NUM_CHANNELS) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [31:0]       write_data,
    input  logic              read,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [31:0]       read_data,
    output logic              read_valid,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [3:0]        cmd_channel,
    output logic [2:0]        cmd_shape,
    output logic [6:0]        cmd_operation,
    output logic              irq
);

    localparam int c_ptr_w = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    // Per-channel architectural state
    logic [2:0]              r_shape [NUM_CHANNELS];
    logic [6:0]              r_op    [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_pending;
    logic [NUM_CHANNELS-1:0] r_err;
    logic [c_ptr_w-1:0]      r_rr_ptr;

    // Write decode
    logic [ADDR_W-1:0]       w_wr_ch;
    logic                    w_wr_reg;
    logic [2:0]              w_wr_shape;
    logic [6:0]              w_wr_op;
    logic                    w_wr_start;
    logic                    w_wr_fields_ok;
    logic [NUM_CHANNELS-1:0] w_ctrl_hit;
    logic [NUM_CHANNELS-1:0] w_ctrl_we;

    // Read decode
    logic [ADDR_W-1:0]       w_rd_ch;
    logic                    w_rd_reg;
    logic [31:0]             w_rd_value;

    // Command stage
    logic [NUM_CHANNELS-1:0] w_in_flight;
    logic [NUM_CHANNELS-1:0] w_req;
    logic [NUM_CHANNELS-1:0] w_grant;
    logic                    w_grant_valid;
    logic [c_ptr_w-1:0]      w_win_ptr;
    logic [c_ptr_w-1:0]      w_win_next;
    logic [2:0]              w_win_shape;
    logic [6:0]              w_win_op;
    logic                    w_accept;
    logic                    w_load;

    // Reserved CTRL bits (and ERR_CLR in the default build) are don't-care
    logic                    w_unused;
    assign w_unused = ^write_data;

    assign w_wr_ch        = write_addr >> 1;
    assign w_wr_reg       = write_addr[0];
    assign w_wr_shape     = write_data[c_shape_lsb +: 3];
    assign w_wr_op        = write_data[c_op_lsb +: 7];
    assign w_wr_start     = write_data[c_start_bit];
    assign w_wr_fields_ok = !is_reserved_shape(w_wr_shape) && !is_reserved_operation(w_wr_op);

    assign w_rd_ch  = read_addr >> 1;
    assign w_rd_reg = read_addr[0];

    // Per-channel legality: KEEP resolves against the stored field, and a
    // channel with a queued START refuses reconfiguration until accepted.
    // Channel indices beyond NUM_CHANNELS never match and are ignored.
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        localparam logic [ADDR_W-1:0] c_idx = ADDR_W'(g);
        logic [2:0] w_res_shape;
        logic [6:0] w_res_op;

        assign w_res_shape   = (w_wr_shape == KEEP_SHAPE)   ? r_shape[g] : w_wr_shape;
        assign w_res_op      = (w_wr_op == KEEP_OPERATION)  ? r_op[g]    : w_wr_op;
        assign w_ctrl_hit[g] = write && (w_wr_ch == c_idx) && (w_wr_reg == c_reg_ctrl);
        assign w_ctrl_we[g]  = w_ctrl_hit[g] && w_wr_fields_ok && !r_pending[g]
                               && is_legal_combination(w_res_shape, w_res_op);
        assign w_in_flight[g] = cmd_valid && (cmd_channel == 4'(g));
    end

    // Channel CTRL fields and pending flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_shape[i] <= CIRCLE;
                r_op[i]    <= PERIMETER;
            end
            r_pending <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (w_ctrl_we[i]) begin
                    if (w_wr_shape != KEEP_SHAPE) begin
                        r_shape[i] <= w_wr_shape;
                    end
                    if (w_wr_op != KEEP_OPERATION) begin
                        r_op[i] <= w_wr_op;
                    end
                    if (w_wr_start) begin
                        r_pending[i] <= 1'b1;
                    end
                end else if (w_accept && (cmd_channel == 4'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // Read data mux over pre-edge state
    always_comb begin
        w_rd_value = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_rd_ch == ADDR_W'(i)) begin
                if (w_rd_reg == c_reg_ctrl) begin
                    w_rd_value = ctrl_sfr_reg'{start:     1'b0,
                                               rsvd_hi:   12'd0,
                                               shape:     r_shape[i],
                                               rsvd_lo:   9'd0,
                                               operation: r_op[i]};
                end else begin
                    w_rd_value = {30'd0, r_err[i], r_pending[i]};
                end
            end
        end
    end

    // Registered read port, one cycle latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= read;
            if (read) begin
                read_data <= w_rd_value;
            end
        end
    end

    // Channel already sitting in the output stage must not be granted again
    assign w_req = r_pending & ~w_in_flight;

    shape_proc_rr_arbiter #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .PTR_W        (c_ptr_w)
    ) u_arb (
        .req         (w_req),
        .ptr         (r_rr_ptr),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    // One-hot grant to index and payload snapshot
    always_comb begin
        w_win_ptr   = '0;
        w_win_shape = '0;
        w_win_op    = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_grant[i]) begin
                w_win_ptr   = c_ptr_w'(i);
                w_win_shape = r_shape[i];
                w_win_op    = r_op[i];
            end
        end
    end

    assign w_win_next = (w_win_ptr == c_ptr_w'(NUM_CHANNELS - 1)) ? '0 : w_win_ptr + 1'b1;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_load     = !cmd_valid || cmd_ready;

    // One-entry command register: refills when empty or on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid     <= 1'b0;
            cmd_channel   <= '0;
            cmd_shape     <= '0;
            cmd_operation <= '0;
            r_rr_ptr      <= '0;
        end else if (w_load) begin
            cmd_valid <= w_grant_valid;
            if (w_grant_valid) begin
                cmd_channel   <= 4'(w_win_ptr);
                cmd_shape     <= w_win_shape;
                cmd_operation <= w_win_op;
                r_rr_ptr      <= w_win_next;
            end
        end
    end

`ifdef SHAPE_PROC_ERR_IRQ_EN
    logic [NUM_CHANNELS-1:0] w_err_set;
    logic [NUM_CHANNELS-1:0] w_err_clr;
    logic                    r_irq;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_err
        assign w_err_set[g] = w_ctrl_hit[g] && !w_ctrl_we[g];
        assign w_err_clr[g] = write && (w_wr_ch == ADDR_W'(g)) && (w_wr_reg == c_reg_status)
                              && write_data[c_err_clr_bit];
    end

    // Sticky error flags (set beats clear) and registered interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= '0;
            r_irq <= 1'b0;
        end else begin
            r_err <= w_err_set | (r_err & ~w_err_clr);
            r_irq <= |r_err;
        end
    end

    assign irq = r_irq;
`else
    assign r_err = '0;
    assign irq   = 1'b0;
`endif

endmodule
`default_nettype wire
